// File: rtl/cgra_col_seq.sv
// ---------------------------------------------------------------------------
// cgra_col_seq -- column sequencer for a CGRA reconfigurable-cell column.
//
// Walks a kernel through the column's configuration-word memory. A start
// pulse in IDLE loads the program counter and runs IDLE -> LOAD -> EXEC ->
// DONE -> IDLE. In EXEC the PC advances (or branches) on every unstalled
// cycle. Two saturating performance counters track committed instructions
// and stalled EXEC cycles.
//
// Parameters
//   NUM_CREG_LOG2 : PC width (configuration-word index)
//   CNT_WIDTH     : performance counter width
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : asynchronous active-high reset
//   start_i        : kernel launch pulse (accepted in IDLE only)
//   start_pc_i     : first configuration-word index of the kernel
//   abort_i        : soft abort, returns to IDLE without a done pulse
//   rcs_stall_i    : merged column stall from the RC array
//   rcs_br_req_i   : merged column branch request
//   rcs_br_add_i   : branch target
//   exec_end_i     : column execution-end indication
//   rcs_pc_o       : column PC driven to the RCs
//   rcs_pc_e_o     : PC enable, RCs commit results while high
//   rcs_conf_re_o  : configuration-word read enable
//   busy_o         : high whenever the sequencer is not IDLE
//   done_o         : one-cycle kernel completion pulse
//   exec_cnt_o     : committed instruction count
//   stall_cnt_o    : stalled EXEC cycle count
// ---------------------------------------------------------------------------
module cgra_col_seq #(
    parameter int NUM_CREG_LOG2 = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [NUM_CREG_LOG2-1:0] start_pc_i,
    input  logic                     abort_i,
    input  logic                     rcs_stall_i,
    input  logic                     rcs_br_req_i,
    input  logic [NUM_CREG_LOG2-1:0] rcs_br_add_i,
    input  logic                     exec_end_i,
    output logic [NUM_CREG_LOG2-1:0] rcs_pc_o,
    output logic                     rcs_pc_e_o,
    output logic                     rcs_conf_re_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_WIDTH-1:0]     exec_cnt_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                     state_q, state_d;
    logic [NUM_CREG_LOG2-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]       exec_cnt_q, exec_cnt_d;
    logic [CNT_WIDTH-1:0]       stall_cnt_q, stall_cnt_d;

    // State register and datapath flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            exec_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            exec_cnt_q  <= exec_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state / datapath update. Abort is checked first in every busy
    // state so it overrides stall, branch and end handling; PC and counters
    // keep their values on an abort.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        exec_cnt_d  = exec_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pc_d        = start_pc_i;
                    exec_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                state_d = abort_i ? ST_IDLE : ST_EXEC;
            end

            ST_EXEC: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rcs_stall_i) begin
                    if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    if (exec_cnt_q != CNT_MAX) begin
                        exec_cnt_d = exec_cnt_q + CNT_WIDTH'(1);
                    end
                    // Branch wins over end-of-execution; PC wraps naturally
                    // at the top of the configuration memory.
                    if (rcs_br_req_i) begin
                        pc_d = rcs_br_add_i;
                    end else begin
                        pc_d = pc_q + NUM_CREG_LOG2'(1);
                        if (exec_end_i) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decodes depend only on the registered state and the stall
    // input, so no input reaches the PC combinationally.
    always_comb begin
        rcs_pc_e_o    = (state_q == ST_EXEC) && !rcs_stall_i;
        rcs_conf_re_o = (state_q == ST_LOAD) || (state_q == ST_EXEC);
        busy_o        = (state_q != ST_IDLE);
        done_o        = (state_q == ST_DONE);
    end

    assign rcs_pc_o    = pc_q;
    assign exec_cnt_o  = exec_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_cgra_col_seq.sv
// ---------------------------------------------------------------------------
// tb_cgra_col_seq -- self-checking bench for cgra_col_seq.
// Directed kernel runs (linear, stall, branch/wrap, branch+end, abort,
// reset, ignored start, counter saturation) followed by a random run. A
// behavioural model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cgra_col_seq;

    localparam int PCW   = 5;
    localparam int CW    = 4;               // small so saturation is reachable
    localparam int PCMOD = 1 << PCW;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_EXEC = 2;
    localparam int M_DONE = 3;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic [PCW-1:0] start_pc_i;
    logic           abort_i;
    logic           rcs_stall_i;
    logic           rcs_br_req_i;
    logic [PCW-1:0] rcs_br_add_i;
    logic           exec_end_i;
    logic [PCW-1:0] rcs_pc_o;
    logic           rcs_pc_e_o;
    logic           rcs_conf_re_o;
    logic           busy_o;
    logic           done_o;
    logic [CW-1:0]  exec_cnt_o;
    logic [CW-1:0]  stall_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_mode = M_IDLE;
    int m_pc   = 0;
    int m_ec   = 0;
    int m_sc   = 0;

    cgra_col_seq #(
        .NUM_CREG_LOG2 (PCW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .start_pc_i    (start_pc_i),
        .abort_i       (abort_i),
        .rcs_stall_i   (rcs_stall_i),
        .rcs_br_req_i  (rcs_br_req_i),
        .rcs_br_add_i  (rcs_br_add_i),
        .exec_end_i    (exec_end_i),
        .rcs_pc_o      (rcs_pc_o),
        .rcs_pc_e_o    (rcs_pc_e_o),
        .rcs_conf_re_o (rcs_conf_re_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .exec_cnt_o    (exec_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs with what the model predicts for the current
    // mode and the stall input currently applied.
    task automatic check_all(input string tag);
        int e_pe, e_re, e_busy, e_done;
        e_pe   = (m_mode == M_EXEC && !rcs_stall_i) ? 1 : 0;
        e_re   = (m_mode == M_LOAD || m_mode == M_EXEC) ? 1 : 0;
        e_busy = (m_mode != M_IDLE) ? 1 : 0;
        e_done = (m_mode == M_DONE) ? 1 : 0;
        chk({tag, ".pc"},    int'(rcs_pc_o),      m_pc);
        chk({tag, ".pc_e"},  int'(rcs_pc_e_o),    e_pe);
        chk({tag, ".cre"},   int'(rcs_conf_re_o), e_re);
        chk({tag, ".busy"},  int'(busy_o),        e_busy);
        chk({tag, ".done"},  int'(done_o),        e_done);
        chk({tag, ".ecnt"},  int'(exec_cnt_o),    m_ec);
        chk({tag, ".scnt"},  int'(stall_cnt_o),   m_sc);
    endtask

    // Advance the model by one clock given the inputs of that cycle.
    task automatic model_step(input bit st, input int spc, input bit ab,
                              input bit stl, input bit br, input int badd,
                              input bit en);
        if (m_mode == M_IDLE) begin
            if (st) begin
                m_pc = spc; m_ec = 0; m_sc = 0; m_mode = M_LOAD;
            end
        end else if (ab) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_EXEC;
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end else if (stl) begin
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end else begin
            m_ec = (m_ec < CMAX) ? m_ec + 1 : CMAX;
            m_pc = br ? badd : (m_pc + 1) % PCMOD;
            if (en && !br) m_mode = M_DONE;
        end
    endtask

    // One cycle: drive inputs (we sit just after a falling edge), check
    // outputs, clock, update model. Prints one line per transaction.
    task automatic cyc(input string tag, input bit st, input int spc,
                       input bit ab, input bit stl, input bit br,
                       input int badd, input bit en);
        start_i      = st;
        start_pc_i   = PCW'(spc);
        abort_i      = ab;
        rcs_stall_i  = stl;
        rcs_br_req_i = br;
        rcs_br_add_i = PCW'(badd);
        exec_end_i   = en;
        #1;
        check_all(tag);
        vectors++;
        $display("%s st=%0b ab=%0b stl=%0b br=%0b/%0d en=%0b pc=%0d pe=%0b re=%0b busy=%0b done=%0b ec=%0d sc=%0d",
                 tag, st, ab, stl, br, badd, en, rcs_pc_o, rcs_pc_e_o,
                 rcs_conf_re_o, busy_o, done_o, exec_cnt_o, stall_cnt_o);
        @(posedge clk_i);
        model_step(st, spc, ab, stl, br, badd, en);
        @(negedge clk_i);
    endtask

    // Plain unstalled EXEC-style cycle helper
    task automatic run(input string tag, input bit en);
        cyc(tag, 0, 0, 0, 0, 0, 0, en);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 0; start_pc_i = '0; abort_i = 0; rcs_stall_i = 0;
        rcs_br_req_i = 0; rcs_br_add_i = '0; exec_end_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check_all("reset");
        vectors++;
        rst_i = 1'b0;
        @(negedge clk_i);

        // Linear run from pc 3, end on the 4th EXEC cycle
        cyc("lin.start", 1, 3, 0, 0, 0, 0, 0);
        run("lin.load", 0);
        chk("lin.pc0", int'(rcs_pc_o), 3);
        run("lin.e1", 0);
        chk("lin.pc1", int'(rcs_pc_o), 4);
        run("lin.e2", 0);
        chk("lin.pc2", int'(rcs_pc_o), 5);
        run("lin.e3", 0);
        chk("lin.pc3", int'(rcs_pc_o), 6);
        run("lin.e4", 1);
        chk("lin.done", int'(done_o), 1);
        chk("lin.ecnt", int'(exec_cnt_o), 4);
        chk("lin.scnt", int'(stall_cnt_o), 0);
        run("lin.donecyc", 0);
        chk("lin.idle", int'(busy_o), 0);

        // Stall at pc 1 for three cycles
        cyc("stl.start", 1, 0, 0, 0, 0, 0, 0);
        run("stl.load", 0);
        run("stl.e0", 0);
        for (int i = 0; i < 3; i++) begin
            cyc("stl.hold", 0, 0, 0, 1, 1, 9, 1);   // branch/end ignored
            chk("stl.pc", int'(rcs_pc_o), 1);
        end
        chk("stl.scnt", int'(stall_cnt_o), 3);
        run("stl.e1", 1);
        run("stl.donecyc", 0);

        // Branch to 31 then wrap to 0; start while busy is ignored
        cyc("br.start", 1, 5, 0, 0, 0, 0, 0);
        cyc("br.load_st", 1, 9, 0, 0, 0, 0, 0);
        cyc("br.e0", 0, 0, 0, 0, 1, 31, 0);
        chk("br.pc31", int'(rcs_pc_o), 31);
        cyc("br.e1_st", 1, 9, 0, 0, 0, 0, 0);
        chk("br.wrap", int'(rcs_pc_o), 0);
        // Branch together with end: branch wins
        cyc("brend", 0, 0, 0, 0, 1, 2, 1);
        chk("brend.pc", int'(rcs_pc_o), 2);
        chk("brend.busy", int'(done_o), 0);
        // Abort mid-EXEC
        cyc("ab.e", 0, 0, 1, 0, 0, 0, 1);
        chk("ab.idle", int'(busy_o), 0);
        run("ab.after", 0);

        // Abort in LOAD
        cyc("abl.start", 1, 7, 0, 0, 0, 0, 0);
        cyc("abl.load", 0, 0, 1, 0, 0, 0, 0);
        run("abl.after", 0);

        // Reset mid-EXEC: outputs clear immediately
        cyc("rst.start", 1, 12, 0, 0, 0, 0, 0);
        run("rst.load", 0);
        run("rst.e0", 0);
        rst_i = 1'b1;
        #1;
        m_mode = M_IDLE; m_pc = 0; m_ec = 0; m_sc = 0;
        check_all("rst.async");
        vectors++;
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc("rst.restart", 1, 20, 0, 0, 0, 0, 0);
        chk("rst.accepted", int'(busy_o), 1);
        run("rst.load2", 0);
        run("rst.e", 1);
        run("rst.donecyc", 0);

        // Saturation of both counters
        cyc("sat.start", 1, 0, 0, 0, 0, 0, 0);
        run("sat.load", 0);
        for (int i = 0; i < CMAX + 4; i++) run("sat.exec", 0);
        chk("sat.ecnt", int'(exec_cnt_o), CMAX);
        for (int i = 0; i < CMAX + 4; i++) cyc("sat.stall", 0, 0, 0, 1, 0, 0, 0);
        chk("sat.scnt", int'(stall_cnt_o), CMAX);
        run("sat.end", 1);
        run("sat.donecyc", 0);

        // Random run against the model
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, PCMOD - 1)),
                ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, PCMOD - 1)),
                ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
